alu_disp_scan: RTL and testbench

ALU_DISP_SCAN -- requirements
Module: alu_disp_scan

---
 rtl/alu_disp_scan.sv | 222 ++++++++++++++++++++++
 tb/tb_alu_disp_scan.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_disp_scan.sv
// -----------------------------------------------------------------------------
// alu_disp_scan
//
// Small registered ALU whose result is shown in hex on a multiplexed,
// active-high 7-segment display.
//
// A one-cycle load strobe captures op(a_in, b_in) into res_out. A free-running
// prescaler advances the scanned digit index every SCAN_DIV cycles. The
// segment/digit drivers are registered from the current index and result, so
// they follow any change with one cycle of lag. Nothing is shown until the
// first result has been captured.
//
// Parameters
//   WIDTH    operand width (2..12)
//   DIGITS   number of display digits (>= ceil((WIDTH+1)/4))
//   SCAN_DIV cycles each digit is shown (>= 2)
//
// Ports
//   clk       rising-edge clock
//   rst       synchronous, active-high reset
//   a_in      operand A (unsigned, WIDTH bits)
//   b_in      operand B (unsigned, WIDTH bits)
//   op_in     00 add, 01 sub, 10 and, 11 xor
//   load_in   capture strobe
//   res_out   registered result, bit WIDTH = carry/borrow
//   valid_out high once any result has been captured
//   zero_out  high when a captured result equals zero
//   seg_out   segments g..a (bit 6 = g), active-high
//   dig_out   one-hot digit enable, bit 0 = least-significant digit
//
// Build option
//   ALU_DISP_BLANK_EN  when defined, leading-zero digits above digit 0 are
//                      blanked (no digit enable, no segments in their slot).
// -----------------------------------------------------------------------------
module alu_disp_scan #(
    parameter int WIDTH    = 4,
    parameter int DIGITS   = 2,
    parameter int SCAN_DIV = 1000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  a_in,
    input  logic [WIDTH-1:0]  b_in,
    input  logic [1:0]        op_in,
    input  logic              load_in,
    output logic [WIDTH:0]    res_out,
    output logic              valid_out,
    output logic              zero_out,
    output logic [6:0]        seg_out,
    output logic [DIGITS-1:0] dig_out
);

    localparam int PW   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW   = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PADW = 4 * DIGITS;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic [WIDTH:0]    res_reg;
    logic              valid_reg;
    logic              zero_reg;
    logic [PW-1:0]     presc_reg;
    logic [IW-1:0]     idx_reg;
    logic [6:0]        seg_reg;
    logic [DIGITS-1:0] dig_reg;

    logic [6:0]        seg_next;
    logic [DIGITS-1:0] dig_next;

    // -------------------------------------------------------------------------
    // ALU: operands are zero-extended by one bit so the top bit of the result
    // carries the add carry-out or the subtract borrow. The logical ops leave
    // that bit at 0 because both extended operands have it clear.
    // -------------------------------------------------------------------------
    logic [WIDTH:0] a_ext;
    logic [WIDTH:0] b_ext;
    logic [WIDTH:0] alu_result;

    always_comb begin
        a_ext = {1'b0, a_in};
        b_ext = {1'b0, b_in};
        case (op_in)
            OP_ADD:  alu_result = a_ext + b_ext;
            OP_SUB:  alu_result = a_ext - b_ext;
            OP_AND:  alu_result = a_ext & b_ext;
            default: alu_result = a_ext ^ b_ext;
        endcase
    end

    // -------------------------------------------------------------------------
    // Scan timing
    // -------------------------------------------------------------------------
    logic presc_wrap;
    logic idx_last;

    assign presc_wrap = (presc_reg == PW'(SCAN_DIV - 1));
    assign idx_last   = (idx_reg == IW'(DIGITS - 1));

    // -------------------------------------------------------------------------
    // Per-digit nibble, one-hot enable and leading-zero flag
    // -------------------------------------------------------------------------
    logic [PADW-1:0]   res_pad;
    logic [3:0]        nibble [DIGITS];
    logic [DIGITS-1:0] dig_onehot;
    logic [DIGITS-1:0] upper_zero;

    // Result zero-extended to a whole number of nibbles.
    assign res_pad = PADW'(res_reg);

    generate
        for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign nibble[gi]     = res_pad[4*gi +: 4];
            assign dig_onehot[gi] = (idx_reg == IW'(gi));
            // Digit 0 always shows, so it never reports as a leading zero.
            if (gi == 0) begin : g_lsd
                assign upper_zero[gi] = 1'b0;
            end else begin : g_upper
                assign upper_zero[gi] = (res_pad[PADW-1:4*gi] == '0);
            end
        end
    endgenerate

    // -------------------------------------------------------------------------
    // Hex to 7-segment (g..a, active-high)
    // -------------------------------------------------------------------------
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] code;
        case (nib)
            4'h0: code = 7'h3F;
            4'h1: code = 7'h06;
            4'h2: code = 7'h5B;
            4'h3: code = 7'h4F;
            4'h4: code = 7'h66;
            4'h5: code = 7'h6D;
            4'h6: code = 7'h7D;
            4'h7: code = 7'h07;
            4'h8: code = 7'h7F;
            4'h9: code = 7'h6F;
            4'hA: code = 7'h77;
            4'hB: code = 7'h7C;
            4'hC: code = 7'h39;
            4'hD: code = 7'h5E;
            4'hE: code = 7'h79;
            default: code = 7'h71;
        endcase
        return code;
    endfunction

    // -------------------------------------------------------------------------
    // Display next-state, built from the registered index and result so the
    // outputs trail every change by exactly one cycle.
    // -------------------------------------------------------------------------
    logic [3:0] nib_sel;
    logic       zero_sel;
    logic       blank_sel;

    always_comb begin
        nib_sel  = '0;
        zero_sel = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (idx_reg == IW'(k)) begin
                nib_sel  = nibble[k];
                zero_sel = upper_zero[k];
            end
        end

`ifdef ALU_DISP_BLANK_EN
        blank_sel = zero_sel;
`else
        blank_sel = 1'b0 & zero_sel;
`endif

        seg_next = '0;
        dig_next = '0;
        if (valid_reg && !blank_sel) begin
            seg_next = seg_decode(nib_sel);
            dig_next = dig_onehot;
        end
    end

    // -------------------------------------------------------------------------
    // Registers. Reset wins over everything, including a same-cycle load.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            res_reg   <= '0;
            valid_reg <= 1'b0;
            zero_reg  <= 1'b0;
            presc_reg <= '0;
            idx_reg   <= '0;
            seg_reg   <= '0;
            dig_reg   <= '0;
        end else begin
            presc_reg <= presc_wrap ? '0 : presc_reg + PW'(1);
            if (presc_wrap) begin
                idx_reg <= idx_last ? '0 : idx_reg + IW'(1);
            end

            // A load and a prescaler wrap in the same cycle are independent.
            if (load_in) begin
                res_reg   <= alu_result;
                valid_reg <= 1'b1;
                zero_reg  <= (alu_result == '0);
            end

            seg_reg <= seg_next;
            dig_reg <= dig_next;
        end
    end

    assign res_out   = res_reg;
    assign valid_out = valid_reg;
    assign zero_out  = zero_reg;
    assign seg_out   = seg_reg;
    assign dig_out   = dig_reg;

endmodule

// File: tb/tb_alu_disp_scan.sv
module tb_alu_disp_scan;

    localparam int WIDTH    = 4;
    localparam int DIGITS   = 2;
    localparam int SCAN_DIV = 4;
    localparam int NVEC     = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  a_in;
    logic [3:0]  b_in;
    logic [1:0]  op_in;
    logic        load_in;
    logic [4:0]  res_out;
    logic        valid_out;
    logic        zero_out;
    logic [6:0]  seg_out;
    logic [1:0]  dig_out;

    always #5 clk = ~clk;

    alu_disp_scan #(
        .WIDTH    (WIDTH),
        .DIGITS   (DIGITS),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .a_in      (a_in),
        .b_in      (b_in),
        .op_in     (op_in),
        .load_in   (load_in),
        .res_out   (res_out),
        .valid_out (valid_out),
        .zero_out  (zero_out),
        .seg_out   (seg_out),
        .dig_out   (dig_out)
    );

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic [4:0] res;
        logic       zero;
    } vec_t;

    vec_t       vecs [NVEC];
    logic [6:0] seg_codes [16];
    logic [4:0] exp_q [$];

    int errors = 0;
    int checks = 0;

    // Reference state of the display path.
    int         m_presc;
    int         m_idx;
    logic [4:0] m_res;
    logic       m_valid;
    logic [6:0] m_seg;
    logic [1:0] m_dig;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive a load for the next edge; the expected result is queued unless
    // reset is also active (reset wins, so nothing will come out).
    task automatic drive_load(input int i);
        a_in    = vecs[i].a;
        b_in    = vecs[i].b;
        op_in   = vecs[i].op;
        load_in = 1'b1;
        if (!rst) exp_q.push_back(vecs[i].res);
    endtask

    // One clock: advance the reference on the edge, compare at the negedge.
    task automatic cycle();
        logic       did_load;
        logic [7:0] pad;
        logic [3:0] nib;
        logic       blank;
        logic [4:0] popped;
        @(posedge clk);
        did_load = load_in && !rst;
        popped   = '0;
        if (rst) begin
            m_presc = 0;
            m_idx   = 0;
            m_res   = '0;
            m_valid = 1'b0;
            m_seg   = '0;
            m_dig   = '0;
        end else begin
            pad   = {3'b000, m_res};
            nib   = (m_idx == 0) ? pad[3:0] : pad[7:4];
            blank = 1'b0;
`ifdef ALU_DISP_BLANK_EN
            if (m_idx != 0 && pad[7:4] == 4'h0) blank = 1'b1;
`endif
            if (m_valid && !blank) begin
                m_seg = seg_codes[nib];
                m_dig = (m_idx == 0) ? 2'b01 : 2'b10;
            end else begin
                m_seg = '0;
                m_dig = '0;
            end
            if (m_presc == SCAN_DIV - 1) begin
                m_presc = 0;
                m_idx   = (m_idx == DIGITS - 1) ? 0 : m_idx + 1;
            end else begin
                m_presc = m_presc + 1;
            end
            if (did_load) begin
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL scoreboard: got empty queue expected one entry at %0t", $time);
                end else begin
                    popped  = exp_q.pop_front();
                    m_res   = popped;
                    m_valid = 1'b1;
                end
            end
        end
        @(negedge clk);
        if (did_load) begin
            $display("load a=%0d b=%0d op=%0d -> res_out=%b zero_out=%0b (expected %b)",
                     a_in, b_in, op_in, res_out, zero_out, popped);
            check("load_res", res_out, popped);
        end
        check("res_out", res_out, m_res);
        check("valid_out", valid_out, m_valid);
        check("zero_out", zero_out, m_valid && (m_res == 5'd0));
        check("dig_out", dig_out, m_dig);
        check("seg_out", seg_out, m_seg);
    endtask

    task automatic idle(input int n);
        load_in = 1'b0;
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        int  budget;
        vecs[0] = '{4'd9,  4'd8,  2'b00, 5'b10001, 1'b0};
        vecs[1] = '{4'd3,  4'd5,  2'b01, 5'b11110, 1'b0};
        vecs[2] = '{4'd5,  4'd5,  2'b11, 5'b00000, 1'b1};
        vecs[3] = '{4'd12, 4'd10, 2'b10, 5'b01000, 1'b0};
        vecs[4] = '{4'd15, 4'd15, 2'b00, 5'b11110, 1'b0};
        vecs[5] = '{4'd0,  4'd0,  2'b01, 5'b00000, 1'b1};
        vecs[6] = '{4'd7,  4'd9,  2'b11, 5'b01110, 1'b0};
        vecs[7] = '{4'd15, 4'd1,  2'b01, 5'b01110, 1'b0};
        vecs[8] = '{4'd0,  4'd1,  2'b01, 5'b11111, 1'b0};
        vecs[9] = '{4'd6,  4'd9,  2'b10, 5'b00000, 1'b1};

        seg_codes = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

        m_presc = 0; m_idx = 0; m_res = '0; m_valid = 1'b0; m_seg = '0; m_dig = '0;
        rst = 1'b1; load_in = 1'b0; a_in = '0; b_in = '0; op_in = '0;

        // Reset for two cycles, then idle: display must stay dark.
        cycle();
        cycle();
        rst = 1'b0;
        idle(12);

        // Table: one load each, then a full scan of both digits.
        for (int i = 0; i < NVEC; i++) begin
            drive_load(i);
            cycle();
            check("vec_zero", zero_out, vecs[i].zero);
            idle(2 * SCAN_DIV * DIGITS);
        end

        // Back-to-back loads on consecutive cycles.
        for (int i = 3; i < 7; i++) begin
            drive_load(i);
            cycle();
        end
        idle(2 * SCAN_DIV * DIGITS);

        // Load on the same edge as a prescaler wrap.
        budget = 0;
        load_in = 1'b0;
        while (m_presc != SCAN_DIV - 1 && budget < 20) begin
            cycle();
            budget++;
        end
        check("wrap_align", m_presc, SCAN_DIV - 1);
        drive_load(1);
        cycle();
        idle(2 * SCAN_DIV * DIGITS);

        // Reset while digit 1 is displayed.
        drive_load(0);
        cycle();
        load_in = 1'b0;
        budget = 0;
        while (dig_out !== 2'b10 && budget < 20) begin
            cycle();
            budget++;
        end
        check("midscan_dig", dig_out, 2'b10);
        rst = 1'b1;
        cycle();
        check("midscan_rst_dig", dig_out, 2'b00);
        check("midscan_rst_valid", valid_out, 1'b0);
        rst = 1'b0;
        idle(6);
        drive_load(6);
        cycle();
        idle(2 * SCAN_DIV * DIGITS);

        // Reset and load together: reset wins.
        rst = 1'b1;
        drive_load(4);
        cycle();
        check("rst_over_load_res", res_out, 5'd0);
        rst = 1'b0;
        idle(6);

        check("queue_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
